// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high segment patterns, bit0 = a .. bit6 = g, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Index of the most-significant nonzero nibble; 0 when the word is zero.
  function automatic logic [2:0] ms_nibble(input logic [31:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex7seg_decode.sv
// Combinational nibble to active-high seven-segment decoder.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with per-frame snapshot and guard gaps.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned GUARD_CYC      = 16,
  parameter int unsigned NUM_DIGITS     = 8,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value_in,
  input  logic [14:0]           led_in,
  input  logic                  blank_in,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [14:0]           led_out,
  output logic                  frame_done
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [SW-1:0]         slot_cnt;
  logic [DW-1:0]         digit_idx;
  state_t                state, state_nx;
  logic [31:0]           shadow;
  logic                  slot_last, digit_last, frame_wrap;
  logic [2:0]            nib_sel;
  logic [3:0]            nibble;
  logic [6:0]            seg_hi, seg_sel;
  logic [NUM_DIGITS-1:0] an_hi;
  logic                  digit_shown;

  assign slot_last  = (slot_cnt == SW'(SCAN_DIV - 1));
  assign digit_last = (digit_idx == DW'(NUM_DIGITS - 1));
  assign frame_wrap = slot_last && digit_last;

  // Digits beyond the eighth reuse shadow nibbles modulo 8.
  assign nib_sel = 3'(digit_idx);
  assign nibble  = shadow[{nib_sel, 2'b00} +: 4];

  hex7seg_decode u_dec (
    .nibble (nibble),
    .seg    (seg_hi)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [2:0] ms_idx;

  always_ff @(posedge clk) begin
    if (rst)             ms_idx <= '0;
    else if (frame_wrap) ms_idx <= ms_nibble(value_in);
  end

  assign digit_shown = (32'(digit_idx) <= 32'(ms_idx));
`else
  assign digit_shown = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    an_hi    = '0;
    seg_sel  = SEG_BLANK;
    unique case (state)
      S_GUARD: if (slot_cnt == SW'(GUARD_CYC - 1)) state_nx = S_DRIVE;
      S_DRIVE: if (slot_last) state_nx = S_GUARD;
      default: state_nx = S_GUARD;
    endcase
    if (state == S_DRIVE) begin
      seg_sel = seg_hi;
      if (!blank_in && digit_shown) an_hi = NUM_DIGITS'(1) << digit_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      state      <= S_GUARD;
      shadow     <= '0;
      frame_done <= 1'b0;
      led_out    <= '0;
      an_out     <= AN_OFF;
      seg_out    <= SEG_OFF;
    end else begin
      state      <= state_nx;
      led_out    <= led_in;
      frame_done <= frame_wrap;
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_wrap) shadow <= value_in;
      an_out  <= AN_ACTIVE_LOW ? ~an_hi : an_hi;
      seg_out <= SEG_ACTIVE_LOW ? ~seg_sel : seg_sel;
    end
  end

  assign dp_out = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl; expectations come from a cycle-index model.
module tb_seg7_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int GUARD_CYC = 1;
  localparam int ND        = 8;
  localparam int FRAME     = SCAN_DIV * ND;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          blank_in = 1'b0;
  logic [31:0]   value_in = '0;
  logic [14:0]   led_in = '0;
  logic [ND-1:0] an_out;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [14:0]   led_out;
  logic          frame_done;

  seg7_scan_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .GUARD_CYC      (GUARD_CYC),
    .NUM_DIGITS     (ND),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .led_in     (led_in),
    .blank_in   (blank_in),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .led_out    (led_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          fd;
    logic [14:0]   led;
  } exp_t;

  exp_t sb[$];

  logic [6:0] hex_tb [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] shadow_m = '0;
`ifdef SEG7_LZ_BLANK_EN
  bit lz = 1'b1;
`else
  bit lz = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected registered outputs for the state cycle that ends at this edge.
  task automatic model_edge();
    exp_t       e;
    int         slot, dig, ms;
    bit         drive;
    logic [7:0] an_hi;
    logic [6:0] seg_hi;
    if (rst) begin
      e.an  = '1;
      e.seg = 7'h7F;
      e.fd  = 1'b0;
      e.led = '0;
      cyc      = 0;
      shadow_m = '0;
    end else begin
      slot  = cyc % SCAN_DIV;
      dig   = (cyc / SCAN_DIV) % ND;
      drive = (slot >= GUARD_CYC);
      ms    = 0;
      for (int i = 0; i < 8; i++) if (shadow_m[4*i +: 4] != 4'h0) ms = i;
      seg_hi = drive ? hex_tb[shadow_m[4*(dig%8) +: 4]] : 7'h00;
      an_hi  = (drive && !blank_in && (!lz || dig <= ms)) ? 8'(1 << dig) : 8'h00;
      e.an  = ~an_hi;
      e.seg = ~seg_hi;
      e.fd  = ((cyc % FRAME) == FRAME - 1);
      e.led = led_in;
      if (e.fd) shadow_m = value_in;
      cyc++;
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("an_out", 32'(an_out), 32'(e.an));
      check("seg_out", 32'(seg_out), 32'(e.seg));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      check("led_out", 32'(led_out), 32'(e.led));
    end
    check("an_overlap", 32'($countones(~an_out) <= 1), 32'd1);
    check("dp_out", 32'(dp_out), 32'd1);
    led_in = 15'($urandom);
  endtask

  task automatic wait_cyc(input int frame_pos);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((cyc % FRAME) == frame_pos) break;
      tick();
    end
    check("wait_position", 32'(cyc % FRAME), 32'(frame_pos));
  endtask

  initial begin
    rst      = 1'b1;
    value_in = 32'h1234_5678;
    tick();
    tick();
    rst = 1'b0;
    repeat (80) tick();

    // Snapshot holds AAAAAAAA, then the input changes while digit 3 is shown.
    value_in = 32'hAAAA_AAAA;
    repeat (40) tick();
    wait_cyc(3 * SCAN_DIV);
    value_in = 32'hFFFF_FFFF;
    repeat (70) tick();

    // Blanking held for 10 clocks starting mid-slot.
    wait_cyc(2 * SCAN_DIV + 2);
    blank_in = 1'b1;
    repeat (10) tick();
    blank_in = 1'b0;
    repeat (40) tick();

    // One-clock reset while driving digit 5.
    wait_cyc(5 * SCAN_DIV + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (70) tick();

    value_in = 32'h0000_00A3;
    repeat (70) tick();
    value_in = 32'h0;
    repeat (70) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
